mem_wb_stage: RTL

Parametrised MEM/WB pipeline register for the MIPS core. Sits between the data-memory stage and the register-file write port. Over the fixed single-issue version it adds:
- a valid/ready handshake with stall and flush;
- configurable data and register-address widths;
- sub-word load alignment with sign/zero extension;
- a retired-instruction counter.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/load_align.sv | 75 +++++++
 rtl/mem_wb_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and default widths for the MIPS MEM/WB slice.
//   ld_type_t    : load type carried alongside a memory read
//   DEFAULT_DW   : datapath width (32 or 64)
//   DEFAULT_AW   : register-file address width
//   DEFAULT_CNTW : retired-instruction counter width
// Encodings 5..7 of a load type are not named; consumers treat them as WORD.
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    LD_WORD  = 3'd0,
    LD_HALF  = 3'd1,
    LD_HALFU = 3'd2,
    LD_BYTE  = 3'd3,
    LD_BYTEU = 3'd4
  } ld_type_t;

  localparam int DEFAULT_DW   = 32;
  localparam int DEFAULT_AW   = 5;
  localparam int DEFAULT_CNTW = 32;

  // True for the load types whose result is sign-extended.
  function automatic logic isSignedLoad(input logic [2:0] ldtype);
    return (ldtype == LD_HALF) || (ldtype == LD_BYTE) ||
           !((ldtype == LD_HALFU) || (ldtype == LD_BYTEU));
  endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational sub-word load alignment. Picks a byte, halfword or word lane
// out of a little-endian memory word (lane 0 = bits [7:0]) and sign- or
// zero-extends it to the datapath width.
// Parameters:
//   DW      : datapath width, 32 or 64
// Ports:
//   ldtype  : in  [2:0]  load type (ld_type_t encoding; unknown codes = WORD)
//   addr_lo : in  [2:0]  low address bits selecting the lane
//   rdata   : in  [DW]   raw memory read word
//   aligned : out [DW]   aligned and extended result
// -----------------------------------------------------------------------------
module load_align
  import mips_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic [2:0]    ldtype,
  input  logic [2:0]    addr_lo,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] aligned
);

  // Number of address bits that index a byte within one datapath word.
  localparam int LW = (DW == 64) ? 3 : 2;

  logic [LW-1:0] laneB;
  logic [LW-1:0] laneH;
  logic [LW-1:0] laneW;
  logic [DW-1:0] shiftedB;
  logic [DW-1:0] shiftedH;
  logic [DW-1:0] shiftedW;
  logic [7:0]    byteV;
  logic [15:0]   halfV;
  logic [31:0]   wordV;
  logic          signExt;

  // Halfword lanes ignore addr_lo[0]; byte lanes use every in-word bit.
  assign laneB = addr_lo[LW-1:0];
  assign laneH = {addr_lo[LW-1:1], 1'b0};

  // Only a 64-bit datapath has two words to choose between; on 32 bits the
  // word is always lane 0 and addr_lo[2] carries no information.
  generate
    if (DW == 64) begin : g_word64
      assign laneW = {addr_lo[2], 2'b00};
    end else begin : g_word32
      logic unused_addrHi;
      assign unused_addrHi = addr_lo[2];
      assign laneW = '0;
    end
  endgenerate

  assign shiftedB = rdata >> {laneB, 3'b000};
  assign shiftedH = rdata >> {laneH, 3'b000};
  assign shiftedW = rdata >> {laneW, 3'b000};

  assign byteV   = shiftedB[7:0];
  assign halfV   = shiftedH[15:0];
  assign wordV   = shiftedW[31:0];
  assign signExt = isSignedLoad(ldtype);

  always_comb begin
    aligned = '0;
    case (ldtype)
      LD_BYTE,
      LD_BYTEU: aligned = signExt ? DW'($signed(byteV)) : DW'(byteV);
      LD_HALF,
      LD_HALFU: aligned = signExt ? DW'($signed(halfV)) : DW'(halfV);
      default:  aligned = DW'($signed(wordV));
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM/WB pipeline register with valid/ready handshake, flush, write-back data
// selection (ALU result or aligned load data) and a retired-instruction
// counter.
//
// Build option:
//   MEMWB_LOAD_ALIGN_EN  defined   -> load data goes through load_align
//                        undefined -> load data passes through unmodified and
//                                     em_ldtype / em_addr_lo are ignored
//
// Parameters: DW (32 or 64), AW (register address width), CNTW (counter width)
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   em_valid         : in  MEM stage presents an instruction
//   em_ready         : out stage can take an instruction this cycle
//   em_regwrite      : in  instruction writes the register file
//   em_memtoreg      : in  write-back data from memory (1) or ALU (0)
//   em_ldtype        : in  load type (ld_type_t)
//   em_addr_lo       : in  low address bits (byte lane select)
//   em_readdata      : in  raw memory read word
//   em_aluresult     : in  ALU result
//   em_wbaddr        : in  destination register
//   flush            : in  squash held and incoming instruction
//   wb_ready         : in  write-back consumes the held instruction
//   mw_valid         : out register holds a live instruction
//   mw_regwrite      : out live register write to a non-zero register
//   mw_wbaddr        : out destination register
//   mw_wbdata        : out write-back data
//   retired          : out number of instructions consumed by write-back
// -----------------------------------------------------------------------------
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DW   = DEFAULT_DW,
  parameter int AW   = DEFAULT_AW,
  parameter int CNTW = DEFAULT_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            em_valid,
  output logic            em_ready,
  input  logic            em_regwrite,
  input  logic            em_memtoreg,
  input  logic [2:0]      em_ldtype,
  input  logic [2:0]      em_addr_lo,
  input  logic [DW-1:0]   em_readdata,
  input  logic [DW-1:0]   em_aluresult,
  input  logic [AW-1:0]   em_wbaddr,
  input  logic            flush,
  input  logic            wb_ready,
  output logic            mw_valid,
  output logic            mw_regwrite,
  output logic [AW-1:0]   mw_wbaddr,
  output logic [DW-1:0]   mw_wbdata,
  output logic [CNTW-1:0] retired
);

  logic            valid_q,     valid_d;
  logic            regWrite_q,  regWrite_d;
  logic            regWrOut_q,  regWrOut_d;
  logic [AW-1:0]   wbAddr_q,    wbAddr_d;
  logic [DW-1:0]   wbData_q,    wbData_d;
  logic [CNTW-1:0] retired_q,   retired_d;

  logic            accept;
  logic            consume;
  logic [DW-1:0]   loadData;
  logic [DW-1:0]   newData;

`ifdef MEMWB_LOAD_ALIGN_EN
  load_align #(
    .DW(DW)
  ) u_loadAlign (
    .ldtype (em_ldtype),
    .addr_lo(em_addr_lo),
    .rdata  (em_readdata),
    .aligned(loadData)
  );
`else
  // Memory already delivers aligned data; lane/type inputs have no use here.
  logic unused_alignInputs;
  assign unused_alignInputs = ^{em_ldtype, em_addr_lo};
  assign loadData = em_readdata;
`endif

  // Ready depends only on held state and the downstream side, never on
  // em_valid, so no combinational loop forms through the MEM stage.
  assign em_ready = ~valid_q | wb_ready;
  assign accept   = em_valid & em_ready & ~flush;
  assign consume  = valid_q & wb_ready;
  assign newData  = em_memtoreg ? loadData : em_aluresult;

  // Flush wins over accept; fields are only rewritten on accept so a stalled
  // or flushed entry keeps its last contents.
  always_comb begin
    valid_d    = valid_q;
    regWrite_d = regWrite_q;
    wbAddr_d   = wbAddr_q;
    wbData_d   = wbData_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      regWrite_d = em_regwrite;
      wbAddr_d   = em_wbaddr;
      wbData_d   = newData;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // The qualified write enable is computed from next state so the output
  // comes straight from a flop; register 0 is never written.
  assign regWrOut_d = valid_d & regWrite_d & (wbAddr_d != '0);

  // Consumption is counted independently of flush: an instruction leaving
  // to write-back in a flush cycle has still retired.
  assign retired_d = retired_q + CNTW'(consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regWrite_q <= 1'b0;
      regWrOut_q <= 1'b0;
      wbAddr_q   <= '0;
      wbData_q   <= '0;
      retired_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regWrite_q <= regWrite_d;
      regWrOut_q <= regWrOut_d;
      wbAddr_q   <= wbAddr_d;
      wbData_q   <= wbData_d;
      retired_q  <= retired_d;
    end
  end

  assign mw_valid    = valid_q;
  assign mw_regwrite = regWrOut_q;
  assign mw_wbaddr   = wbAddr_q;
  assign mw_wbdata   = wbData_q;
  assign retired     = retired_q;

endmodule
